// File: rtl/mod_program_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : mod_program_loader_if
//  Description : Byte-stream valid/ready channel feeding the program loader.
//                master : the byte source (drives in_valid/in_byte)
//                slave  : the loader (drives in_ready)
//                A byte transfers on a rising clock edge where in_valid and
//                in_ready are both high.
//  Revision    : 1.0  initial release
// ============================================================================
interface mod_program_loader_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_byte;

    modport master (
        output in_valid,
        output in_byte,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_byte,
        output in_ready
    );
endinterface
`default_nettype wire

// File: rtl/mod_program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : mod_program_loader
//  Description : Write side of the CPU instruction ROM. Accepts a framed
//                image over a valid/ready byte stream:
//                  LEN_HI LEN_LO {HI LO} x N CHK
//                packs byte pairs into 16-bit words, writes them to ascending
//                ROM addresses and releases the CPU from reset only once the
//                8-bit frame checksum (including CHK) comes out as zero.
//  Ports       : clk, reset     clock / synchronous active-high reset
//                start          begin a load (honoured in IDLE/DONE/ERROR)
//                stream         byte stream, slave side
//                rom_we/addr/data  ROM write port, one strobe per word
//                cpu_reset      high unless the last load verified
//                busy/done/error   load status
//  Revision    : 1.0  initial release
// ============================================================================
module mod_program_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire logic                  start,
    mod_program_loader_if.slave        stream,
    output logic                       rom_we,
    output logic [ADDR_WIDTH-1:0]      rom_addr,
    output logic [15:0]                rom_data,
    output logic                       cpu_reset,
    output logic                       busy,
    output logic                       done,
    output logic                       error
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN_HI  = 3'd1,
        S_LEN_LO  = 3'd2,
        S_DATA_HI = 3'd3,
        S_DATA_LO = 3'd4,
        S_CHECK   = 3'd5,
        S_DONE    = 3'd6,
        S_ERROR   = 3'd7
    } state_t;

    // Largest legal image, in words; 17 bits so the full 16-bit length can
    // be compared against it without overflow.
    localparam logic [16:0]         MAX_WORDS = 17'(1) << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] IDX_ONE   = (ADDR_WIDTH+1)'(1);

    state_t                r_state;
    state_t                w_state_next;
    logic [7:0]            r_sum;
    logic [15:0]           r_len;
    logic [7:0]            r_hi;
    // One bit wider than the address so an image of exactly 2**ADDR_WIDTH
    // words can be counted to completion.
    logic [ADDR_WIDTH:0]   r_index;

    logic                  w_xfer;
    logic                  w_launch;
    logic [7:0]            w_sum_next;
    logic [15:0]           w_len;
    logic [ADDR_WIDTH:0]   w_index_inc;
    logic                  w_last_word;

    assign w_xfer      = stream.in_valid & stream.in_ready;
    assign w_sum_next  = r_sum + stream.in_byte;
    assign w_len       = {r_len[15:8], stream.in_byte};
    assign w_index_inc = r_index + IDX_ONE;
    assign w_last_word = ({{(16-ADDR_WIDTH){1'b0}}, w_index_inc} == {1'b0, r_len});

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_launch        = 1'b0;
        stream.in_ready = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;
        error           = 1'b0;
        cpu_reset       = 1'b1;

        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                done      = (r_state == S_DONE);
                error     = (r_state == S_ERROR);
                cpu_reset = (r_state != S_DONE);
                if (start) begin
                    w_launch     = 1'b1;
                    w_state_next = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                stream.in_ready = 1'b1;
                busy            = 1'b1;
                if (w_xfer) w_state_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                stream.in_ready = 1'b1;
                busy            = 1'b1;
                if (w_xfer) begin
                    if (w_len == 16'd0)
                        w_state_next = S_CHECK;
                    else if ({1'b0, w_len} > MAX_WORDS)
                        w_state_next = S_ERROR;
                    else
                        w_state_next = S_DATA_HI;
                end
            end
            S_DATA_HI: begin
                stream.in_ready = 1'b1;
                busy            = 1'b1;
                if (w_xfer) w_state_next = S_DATA_LO;
            end
            S_DATA_LO: begin
                stream.in_ready = 1'b1;
                busy            = 1'b1;
                if (w_xfer) w_state_next = w_last_word ? S_CHECK : S_DATA_HI;
            end
            S_CHECK: begin
                stream.in_ready = 1'b1;
                busy            = 1'b1;
                if (w_xfer) w_state_next = (w_sum_next == 8'd0) ? S_DONE : S_ERROR;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: checksum, length, word assembly and ROM write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sum    <= 8'd0;
            r_len    <= 16'd0;
            r_hi     <= 8'd0;
            r_index  <= '0;
            rom_we   <= 1'b0;
            rom_addr <= '0;
            rom_data <= 16'd0;
        end else begin
            rom_we <= 1'b0;
            if (w_launch) begin
                r_sum   <= 8'd0;
                r_index <= '0;
            end else if (w_xfer) begin
                r_sum <= w_sum_next;
                case (r_state)
                    S_LEN_HI:  r_len[15:8] <= stream.in_byte;
                    S_LEN_LO:  r_len[7:0]  <= stream.in_byte;
                    S_DATA_HI: r_hi        <= stream.in_byte;
                    S_DATA_LO: begin
                        // Write lands in the cycle after the low byte; the
                        // next low byte is at least two transfers away, so
                        // the strobe can never stay high for two cycles.
                        rom_we   <= 1'b1;
                        rom_addr <= r_index[ADDR_WIDTH-1:0];
                        rom_data <= {r_hi, stream.in_byte};
                        r_index  <= w_index_inc;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
